alu_sequencer: RTL and testbench

- Multi-cycle control FSM that decodes one 16-bit instruction and sequences the register-file / shifter / 16-bit ALU datapath through register read, compute and writeback.
- Drives the ALU opcode (00 add, 01 sub, 10 and, 11 not-B), operand-source selects, pipeline-register load strobes and register-file write.
- Uses a start/ready handshake with the fetch logic.

---
 rtl/alu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM for the register-file / shifter /
// ALU datapath. It accepts one 16-bit instruction at a time through a
// start/ready handshake, then steps through read, compute and writeback.
module alu_sequencer #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          s,
    input  logic [15:0]   instr,
    output logic          w,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          asel,
    output logic          bsel,
    output logic          vsel,
    output logic          loadc,
    output logic          loads,
    output logic [1:0]    ALUop,
    output logic [1:0]    shift,
    output logic [DW-1:0] sximm8,
    output logic [DW-1:0] sximm5,
    output logic          err
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_CALC,
        S_WRITE_REG
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;

    // Instruction fields, always taken from the held IR.
    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [RW-1:0] rn;
    logic [RW-1:0] rd;
    logic [1:0]    sh;
    logic [RW-1:0] rm;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    // Instruction classes.
    logic is_mov_imm;
    logic is_mov_reg;
    logic is_alu;
    logic is_mvn;
    logic is_cmp;
    logic is_legal;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_legal   = is_mov_imm || is_mov_reg || is_alu;

    // Immediates are sign-extended from the IR regardless of state.
    assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(DW-5){ir[4]}}, ir[4:0]};

    // State register, instruction register and error flag.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && s) begin
                ir  <= instr;
                err <= 1'b0;
            end else if (state == S_DECODE && !is_legal) begin
                err <= 1'b1;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        // NOTE: a default assignment first means every path assigns
        // state_nxt, so no latch is inferred.
        state_nxt = state;
        unique case (state)
            S_WAIT:      if (s) state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_mov_imm)                state_nxt = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn) state_nxt = S_GET_B;
                else if (is_alu)               state_nxt = S_GET_A;
                else                           state_nxt = S_WAIT;
            end
            S_WRITE_IMM: state_nxt = S_WAIT;
            S_GET_A:     state_nxt = S_GET_B;
            S_GET_B:     state_nxt = S_CALC;
            S_CALC:      state_nxt = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_nxt = S_WAIT;
            default:     state_nxt = S_WAIT;
        endcase
    end

    // Moore outputs decoded from state and IR.
    always_comb begin
        w        = (state == S_WAIT);
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 1'b0;
        ALUop    = 2'b00;
        shift    = 2'b00;
        unique case (state)
            S_WRITE_IMM: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                shift   = sh;
            end
            S_CALC: begin
                shift = sh;
                if (is_mov_reg) begin
                    ALUop = 2'b00;
                    asel  = 1'b1;
                end else begin
                    ALUop = op;
                end
                if (is_cmp) loads = 1'b1;
                else        loadc = 1'b1;
            end
            S_WRITE_REG: begin
                writenum = rd;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: table of instructions with expected
// per-instruction behaviour, plus hand-written reset / error / handshake
// sequences.
module tb_alu_sequencer;

    localparam int DW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          s;
    logic [15:0]   instr;
    logic          w;
    logic [RW-1:0] readnum;
    logic [RW-1:0] writenum;
    logic          write;
    logic          loada;
    logic          loadb;
    logic          asel;
    logic          bsel;
    logic          vsel;
    logic          loadc;
    logic          loads;
    logic [1:0]    ALUop;
    logic [1:0]    shift;
    logic [DW-1:0] sximm8;
    logic [DW-1:0] sximm5;
    logic          err;

    alu_sequencer #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .reset_n(reset_n), .s(s), .instr(instr), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
        .vsel(vsel), .loadc(loadc), .loads(loads), .ALUop(ALUop),
        .shift(shift), .sximm8(sximm8), .sximm5(sximm5), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // All strobes packed for compact "nothing asserted" checks.
    function automatic logic [4:0] strobes();
        return {write, loada, loadb, loadc, loads};
    endfunction

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] instr;
        int          lat;
        logic        err;
        logic        wr, la, lb, lc, ls;
        logic [2:0]  wnum, rna, rnb;
        logic [1:0]  alu, sh;
        logic        asel;
    } vec_t;

    vec_t vecs[9];

    // Accept one instruction (s already low, FSM in WAIT) and watch it to completion.
    task automatic run_vec(input vec_t v, input int idx);
        logic       g_wr, g_la, g_lb, g_lc, g_ls, g_asel, g_bsel, g_vsel;
        logic [2:0] g_wnum, g_rna, g_rnb;
        logic [1:0] g_alu, g_sh;
        int         n;
        bit         done;
        string      p;
        p = $sformatf("v%0d_%h", idx, v.instr);
        {g_wr, g_la, g_lb, g_lc, g_ls, g_asel, g_bsel, g_vsel} = '0;
        g_wnum = '0; g_rna = '0; g_rnb = '0; g_alu = '0; g_sh = '0;
        s = 1'b1;
        instr = v.instr;
        tick();
        s = 1'b0;
        check({p, "_decode_w"}, w, 1'b0);
        check({p, "_decode_err"}, err, 1'b0);
        n = 0;
        done = 0;
        while (!done && n < 12) begin
            tick();
            n++;
            if (write) begin g_wr = 1; g_wnum = writenum; g_vsel = vsel; end
            if (loada) begin g_la = 1; g_rna = readnum; end
            if (loadb) begin g_lb = 1; g_rnb = readnum; end
            if (loadc) g_lc = 1;
            if (loads) g_ls = 1;
            if (loadc || loads) begin
                g_alu = ALUop; g_sh = shift; g_asel = asel; g_bsel = bsel;
            end
            if (w) done = 1;
        end
        check({p, "_latency"}, n, v.lat);
        check({p, "_err"}, err, v.err);
        check({p, "_strobes"}, {g_wr, g_la, g_lb, g_lc, g_ls},
              {v.wr, v.la, v.lb, v.lc, v.ls});
        if (v.wr) begin
            check({p, "_writenum"}, g_wnum, v.wnum);
            check({p, "_vsel"}, g_vsel, !v.lc);
        end
        if (v.la) check({p, "_readnum_a"}, g_rna, v.rna);
        if (v.lb) check({p, "_readnum_b"}, g_rnb, v.rnb);
        if (v.lc || v.ls) begin
            check({p, "_aluop"}, g_alu, v.alu);
            check({p, "_shift"}, g_sh, v.sh);
            check({p, "_asel"}, g_asel, v.asel);
            check({p, "_bsel"}, g_bsel, 1'b0);
        end
    endtask

    initial begin
        //            instr     lat err wr la lb lc ls wnum  rna   rnb   alu    sh     asel
        vecs[0] = '{16'hD1FF, 2, 0, 1, 0, 0, 0, 0, 3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 0}; // MOV R1,#-1
        vecs[1] = '{16'hA140, 5, 0, 1, 1, 1, 1, 0, 3'd2, 3'd1, 3'd0, 2'b00, 2'b00, 0}; // ADD R2,R1,R0
        vecs[2] = '{16'hA900, 4, 0, 0, 1, 1, 0, 1, 3'd0, 3'd1, 3'd0, 2'b01, 2'b00, 0}; // CMP R1,R0
        vecs[3] = '{16'hB860, 4, 0, 1, 0, 1, 1, 0, 3'd3, 3'd0, 3'd0, 2'b11, 2'b00, 0}; // MVN R3,R0
        vecs[4] = '{16'h0000, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 0}; // illegal
        vecs[5] = '{16'hC08D, 4, 0, 1, 0, 1, 1, 0, 3'd4, 3'd0, 3'd5, 2'b00, 2'b01, 1}; // MOV R4,R5 LSL
        vecs[6] = '{16'hB6F2, 5, 0, 1, 1, 1, 1, 0, 3'd7, 3'd6, 3'd2, 2'b10, 2'b10, 0}; // AND R7,R6,R2 sh=10
        vecs[7] = '{16'hC800, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 0}; // 110/01 illegal
        vecs[8] = '{16'hE000, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 0}; // opcode 111 illegal

        // Reset state.
        reset_n = 1'b0;
        s = 1'b1;
        instr = 16'hD1FF;
        tick();
        tick();
        check("rst_w", w, 1'b1);
        check("rst_strobes", strobes(), 5'b0);
        check("rst_err", err, 1'b0);
        check("rst_nums", {readnum, writenum, ALUop, shift, vsel, asel, bsel}, '0);
        check("rst_ir_ignores_s", sximm8, 16'h0000);
        s = 1'b0;
        reset_n = 1'b1;
        tick();
        check("idle_w", w, 1'b1);

        // MOV imm, cycle by cycle.
        s = 1'b1;
        instr = 16'hD1FF;
        tick();
        s = 1'b0;
        check("movi_decode_w", w, 1'b0);
        check("movi_decode_strobes", strobes(), 5'b0);
        tick();
        check("movi_wr", {write, vsel, writenum}, {1'b1, 1'b1, 3'd1});
        check("movi_sximm8", sximm8, 16'hFFFF);
        check("movi_sximm5", sximm5, 16'hFFFF);
        tick();
        check("movi_w_back", w, 1'b1);

        // ADD, cycle by cycle.
        s = 1'b1;
        instr = 16'hA140;
        tick();
        s = 1'b0;
        tick();
        check("add_get_a", {loada, loadb, readnum}, {1'b1, 1'b0, 3'd1});
        tick();
        check("add_get_b", {loada, loadb, readnum}, {1'b0, 1'b1, 3'd0});
        tick();
        check("add_calc", {loadc, loads, ALUop, asel, bsel}, {1'b1, 1'b0, 2'b00, 1'b0, 1'b0});
        tick();
        check("add_write", {write, vsel, writenum}, {1'b1, 1'b0, 3'd2});
        tick();
        check("add_w_back", w, 1'b1);

        // Table-driven vectors, run back to back.
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Illegal: err holds in WAIT until the next accept, which clears it.
        s = 1'b1;
        instr = 16'h0000;
        tick();
        s = 1'b0;
        tick();
        check("ill_err_set", {err, w, strobes()}, {1'b1, 1'b1, 5'b0});
        tick();
        tick();
        check("ill_err_holds", err, 1'b1);
        s = 1'b1;
        instr = 16'hD007;
        tick();
        s = 1'b0;
        check("ill_err_cleared", err, 1'b0);
        check("ill_next_sximm8", sximm8, 16'h0007);
        tick();
        check("ill_next_write", {write, writenum}, {1'b1, 3'd0});
        tick();

        // s while busy is ignored; reset during GET_B aborts cleanly.
        s = 1'b1;
        instr = 16'hA140;
        tick();
        instr = 16'hD1FF;           // s stays high while busy
        tick();
        check("busy_ir_held", sximm8, 16'h0040);
        check("busy_get_a", loada, 1'b1);
        tick();
        check("busy_get_b", {loadb, w}, {1'b1, 1'b0});
        reset_n = 1'b0;
        tick();
        check("midrst_w", w, 1'b1);
        check("midrst_strobes", strobes(), 5'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_ir", sximm8, 16'h0000);
        reset_n = 1'b1;

        // Back to back: s held high accepts on the first edge with w=1.
        tick();
        check("b2b_accept", {w, sximm8}, {1'b0, 16'hFFFF});
        tick();
        check("b2b_write_imm", {write, writenum}, {1'b1, 3'd1});
        instr = 16'hB860;
        tick();
        check("b2b_wait", w, 1'b1);
        tick();
        check("b2b_reaccept", {w, sximm8}, {1'b0, 16'h0060});
        s = 1'b0;
        repeat (5) tick();
        check("b2b_done", w, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
